// File: rtl/constraint_sampler_pkg.sv
// Shared types and LFSR helpers for the constraint sampler.
package constraint_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [31:0] LFSR_MASK   = 32'h80200003;
    localparam logic [31:0] SEED_STRIDE = 32'h9E3779B9;

    // 32-bit Galois LFSR, right shift, feedback when the shifted-out bit is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_MASK;
        end
        return r;
    endfunction

endpackage

// File: rtl/constraint_sampler_lane.sv
// One 32-bit LFSR lane; exposes its next state so the top can register cand in step.
module lfsr32_lane
    import constraint_sampler_pkg::*;
#(
    parameter int unsigned IDX = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] state_next
);

    localparam logic [31:0] OFFSET = 32'(IDX) * SEED_STRIDE;

    logic [31:0] lane_q;
    logic [31:0] seeded;

    assign seeded = seed ^ OFFSET;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    always_comb begin
        state_next = lane_q;
        if (load) begin
            state_next = (seeded == 32'h0) ? 32'h1 : seeded;
        end else if (step) begin
            state_next = lfsr_step(lane_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= 32'h1;
        end else begin
            lane_q <= state_next;
        end
    end

endmodule

// File: rtl/constraint_sampler.sv
// Pseudo-random candidate generator that streams only checker-satisfying vectors.
//   state  | meaning
//   IDLE   | waiting for start
//   SEARCH | one candidate attempt per cycle
//   HOLD   | satisfying sample offered until the sink accepts it
module constraint_sampler
    import constraint_sampler_pkg::*;
#(
    parameter int WIDTH     = 512,
    parameter int LANES     = WIDTH / 32,
    parameter int MAX_TRIES = 1048576,
    parameter int CW        = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [15:0]      num_samples,
    output logic [WIDTH-1:0] cand,
    input  logic             sat,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [WIDTH-1:0] sample_data,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CW-1:0]    attempts
);

    localparam logic [CW-1:0] LAST_TRY = CW'(MAX_TRIES - 1);

    if (WIDTH != 32 * LANES) begin : g_width_check
        $error("constraint_sampler: WIDTH must equal 32*LANES");
    end

    state_t           state_q;
    state_t           state_d;
    logic             load;
    logic             step;
    logic             capture;
    logic             inc_attempt;
    logic             set_timeout;
    logic             clr_timeout;
    logic             done_d;
    logic             handshake;
    logic [15:0]      remaining;
    logic [WIDTH-1:0] lane_next;

    assign handshake = sample_valid && sample_ready;
    assign busy      = (state_q != IDLE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        lfsr32_lane #(
            .IDX(i)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load),
            .step       (step),
            .seed       (seed),
            .state_next (lane_next[32*i +: 32])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        step        = 1'b0;
        capture     = 1'b0;
        inc_attempt = 1'b0;
        set_timeout = 1'b0;
        clr_timeout = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_timeout = 1'b1;
                    if (num_samples == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (sat) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end else if (attempts == LAST_TRY) begin
                    set_timeout = 1'b1;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end else begin
                    step        = 1'b1;
                    inc_attempt = 1'b1;
                end
            end
            HOLD: begin
                // Stepping on accept guarantees the next sample is a fresh vector.
                if (handshake) begin
                    step = 1'b1;
                    if (remaining == 16'd1) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand         <= '0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
            done         <= 1'b0;
            timeout      <= 1'b0;
            attempts     <= '0;
            remaining    <= 16'd0;
        end else begin
            done <= done_d;
            if (load || step) begin
                cand <= lane_next;
            end
            if (capture) begin
                sample_data  <= cand;
                sample_valid <= 1'b1;
            end else if (handshake) begin
                sample_valid <= 1'b0;
            end
            if (load || handshake) begin
                attempts <= '0;
            end else if (inc_attempt) begin
                attempts <= attempts + CW'(1);
            end
            if (load) begin
                remaining <= num_samples;
            end else if (handshake) begin
                remaining <= remaining - 16'd1;
            end
            if (clr_timeout) begin
                timeout <= 1'b0;
            end else if (set_timeout) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_constraint_sampler.sv
// Randomized bench for constraint_sampler against a behavioural run model.
module tb_constraint_sampler;

    localparam int W        = 128;
    localparam int L        = 4;
    localparam int MAX_MAIN = 1048576;
    localparam int BUDGET   = 20000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start        = 1'b0;
    logic [31:0]   seed         = 32'h0;
    logic [15:0]   num_samples  = 16'd0;
    logic          sat          = 1'b0;
    logic          sample_ready = 1'b0;
    logic [W-1:0]  cand;
    logic [W-1:0]  sample_data;
    logic          sample_valid;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [20:0]   attempts;

    logic          t_start = 1'b0;
    logic [31:0]   t_seed  = 32'h0;
    logic [15:0]   t_num   = 16'd0;
    logic          t_sat   = 1'b0;
    logic          t_ready = 1'b1;
    logic [63:0]   t_cand;
    logic [63:0]   t_data;
    logic          t_valid;
    logic          t_busy;
    logic          t_done;
    logic          t_timeout;
    logic [4:0]    t_attempts;

    constraint_sampler #(.WIDTH(W), .LANES(L), .MAX_TRIES(MAX_MAIN), .CW(21)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .num_samples(num_samples),
        .cand(cand), .sat(sat), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .sample_data(sample_data), .busy(busy), .done(done), .timeout(timeout),
        .attempts(attempts)
    );

    constraint_sampler #(.WIDTH(64), .LANES(2), .MAX_TRIES(16), .CW(5)) u_dut_to (
        .clk(clk), .rst_n(rst_n), .start(t_start), .seed(t_seed), .num_samples(t_num),
        .cand(t_cand), .sat(t_sat), .sample_valid(t_valid), .sample_ready(t_ready),
        .sample_data(t_data), .busy(t_busy), .done(t_done), .timeout(t_timeout),
        .attempts(t_attempts)
    );

    int vectors = 0;
    int errors  = 0;

    int           m_mode;
    logic [31:0]  m_lane [L];
    logic [W-1:0] m_cand;
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_done;
    logic         m_timeout;
    int           m_att;
    int           m_rem;

    int           sat_mode   = 3;
    int           ready_mode = 3;
    int           hs_cnt     = 0;
    int           done_cnt   = 0;
    int           hold_cnt   = 0;
    logic         have_last  = 1'b0;
    logic [W-1:0] last_data  = '0;

    task automatic expect_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h80200003;
        return r;
    endfunction

    task automatic pack_cand();
        for (int i = 0; i < L; i++) m_cand[32*i +: 32] = m_lane[i];
    endtask

    task automatic step_lanes();
        for (int i = 0; i < L; i++) m_lane[i] = ref_step(m_lane[i]);
        pack_cand();
    endtask

    task automatic model_reset();
        m_mode = 0;
        for (int i = 0; i < L; i++) m_lane[i] = 32'h1;
        m_cand = '0; m_data = '0; m_valid = 1'b0; m_done = 1'b0;
        m_timeout = 1'b0; m_att = 0; m_rem = 0;
    endtask

    task automatic model_update();
        logic        nd;
        logic [31:0] v;
        nd = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            0: if (start) begin
                m_timeout = 1'b0;
                if (num_samples == 16'd0) begin
                    nd = 1'b1;
                end else begin
                    for (int i = 0; i < L; i++) begin
                        v = seed ^ (32'(i) * 32'h9E3779B9);
                        m_lane[i] = (v == 32'h0) ? 32'h1 : v;
                    end
                    pack_cand();
                    m_rem = int'(num_samples);
                    m_att = 0;
                    m_mode = 1;
                end
            end
            1: if (sat) begin
                m_data = m_cand; m_valid = 1'b1; m_mode = 2;
            end else if (m_att == MAX_MAIN - 1) begin
                m_timeout = 1'b1; nd = 1'b1; m_mode = 0;
            end else begin
                step_lanes(); m_att++;
            end
            default: if (sample_ready) begin
                m_valid = 1'b0; m_rem--; m_att = 0; step_lanes();
                if (m_rem == 0) begin nd = 1'b1; m_mode = 0; end
                else m_mode = 1;
            end
        endcase
        m_done = nd;
    endtask

    task automatic drive_inputs();
        case (sat_mode)
            0:       sat = (m_cand[7:0] == 8'h00);
            1:       sat = 1'b1;
            2:       sat = ($urandom_range(0, 3) == 0);
            default: sat = 1'b0;
        endcase
        case (ready_mode)
            0:       sample_ready = 1'b1;
            1:       sample_ready = 1'($urandom_range(0, 1));
            2:       sample_ready = (hold_cnt >= 10);
            default: sample_ready = 1'b0;
        endcase
    endtask

    task automatic step_cycle();
        if (sample_valid && sample_ready) begin
            hs_cnt++;
            if (have_last) expect_eq("no_repeat", W'(sample_data != last_data), W'(1));
            if (sat_mode == 0) expect_eq("sat_low_byte", W'(sample_data[7:0]), W'(0));
            last_data = sample_data;
            have_last = 1'b1;
        end
        @(posedge clk);
        model_update();
        #1;
        expect_eq("cand",         cand,                m_cand);
        expect_eq("sample_valid", W'(sample_valid),    W'(m_valid));
        expect_eq("sample_data",  sample_data,         m_data);
        expect_eq("busy",         W'(busy),            W'(m_mode != 0));
        expect_eq("done",         W'(done),            W'(m_done));
        expect_eq("timeout",      W'(timeout),         W'(m_timeout));
        expect_eq("attempts",     W'(attempts),        W'(m_att));
        if (done) done_cnt++;
        if (m_valid) hold_cnt++;
        drive_inputs();
    endtask

    task automatic do_run(input logic [31:0] s, input int n, input int smode, input int rmode);
        int cyc;
        sat_mode = smode; ready_mode = rmode;
        hs_cnt = 0; done_cnt = 0; hold_cnt = 0; have_last = 1'b0;
        drive_inputs();
        seed = s; num_samples = 16'(n); start = 1'b1;
        step_cycle();
        start = 1'b0;
        cyc = 0;
        while (!m_done && cyc < BUDGET) begin
            step_cycle();
            cyc++;
        end
        expect_eq("run_budget",  W'(cyc < BUDGET), W'(1));
        expect_eq("done_pulses", W'(done_cnt),     W'(1));
        expect_eq("handshakes",  W'(hs_cnt),       W'(n));
        expect_eq("run_timeout", W'(timeout),      W'(0));
    endtask

    initial begin
        int cnt;
        int last_att;
        logic seen_valid;

        model_reset();
        drive_inputs();
        step_cycle();
        step_cycle();
        #1 rst_n = 1'b1;
        step_cycle();

        // sat on low byte zero, always-ready sink
        do_run(32'h1, 4, 0, 0);
        // sink stalls 10 cycles on the first sample
        do_run($urandom, 3, 1, 2);
        // zero samples: done only
        do_run($urandom, 0, 1, 0);

        // seed 0: lane 0 substitutes 1, lane 1 gets the stride
        sat_mode = 3; ready_mode = 0; drive_inputs();
        seed = 32'h0; num_samples = 16'd1; start = 1'b1;
        step_cycle();
        start = 1'b0;
        expect_eq("seed0_lane0", W'(cand[31:0]),  W'(32'h00000001));
        expect_eq("seed0_lane1", W'(cand[63:32]), W'(32'h9E3779B9));
        step_cycle();
        expect_eq("seed0_step0", W'(cand[31:0]),  W'(32'h80200003));
        expect_eq("seed0_step1", W'(cand[63:32]), W'(32'hCF3BBCDF));
        sat_mode = 1; drive_inputs();
        cnt = 0;
        while (!m_done && cnt < 50) begin step_cycle(); cnt++; end
        expect_eq("seed0_end", W'(cnt < 50), W'(1));

        for (int r = 0; r < 4; r++) do_run($urandom, $urandom_range(1, 3), 2, 1);

        // free-running random starts, including starts while busy
        sat_mode = 2; ready_mode = 1; have_last = 1'b0;
        for (int c = 0; c < 800; c++) begin
            start = ($urandom_range(0, 15) == 0);
            seed = $urandom;
            num_samples = 16'($urandom_range(0, 3));
            step_cycle();
        end
        start = 1'b0;
        cnt = 0;
        while (m_mode != 0 && cnt < 200) begin step_cycle(); cnt++; end
        expect_eq("rand_drain", W'(cnt < 200), W'(1));

        // asynchronous reset while a sample is held
        sat_mode = 1; ready_mode = 3; drive_inputs();
        seed = $urandom; num_samples = 16'd2; start = 1'b1;
        step_cycle();
        start = 1'b0;
        step_cycle();
        expect_eq("hold_valid", W'(sample_valid), W'(1));
        #2 rst_n = 1'b0;
        #1;
        expect_eq("arst_cand",     cand,             W'(0));
        expect_eq("arst_data",     sample_data,      W'(0));
        expect_eq("arst_valid",    W'(sample_valid), W'(0));
        expect_eq("arst_busy",     W'(busy),         W'(0));
        expect_eq("arst_done",     W'(done),         W'(0));
        expect_eq("arst_timeout",  W'(timeout),      W'(0));
        expect_eq("arst_attempts", W'(attempts),     W'(0));
        step_cycle();
        step_cycle();
        rst_n = 1'b1;
        step_cycle();
        do_run($urandom, 2, 1, 0);

        // abort after MAX_TRIES attempts on the small instance
        sat_mode = 3; ready_mode = 3; drive_inputs();
        t_seed = $urandom; t_num = 16'd1; t_start = 1'b1;
        step_cycle();
        t_start = 1'b0;
        expect_eq("to_cand_nonzero", W'(t_cand != 64'h0), W'(1));
        cnt = 0; last_att = -1; seen_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (t_valid) seen_valid = 1'b1;
            if (t_done) break;
            if (t_busy) begin cnt++; last_att = int'(t_attempts); end
            step_cycle();
        end
        expect_eq("to_done",         W'(t_done),     W'(1));
        expect_eq("to_search_cyc",   W'(cnt),        W'(16));
        expect_eq("to_last_attempt", W'(last_att),   W'(15));
        expect_eq("to_timeout",      W'(t_timeout),  W'(1));
        expect_eq("to_no_valid",     W'(seen_valid), W'(0));
        expect_eq("to_no_data",      W'(t_data),     W'(0));
        t_num = 16'd0; t_start = 1'b1;
        step_cycle();
        t_start = 1'b0;
        expect_eq("to_clear",     W'(t_timeout), W'(0));
        expect_eq("to_zero_done", W'(t_done),    W'(1));
        expect_eq("to_zero_busy", W'(t_busy),    W'(0));
        step_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/constraint_sampler.md
Name: constraint_sampler

Overview:
- Sequential stimulus generator for the generated constraint-checker modules: the producer side of the checker's candidate-in / satisfied-out interface.
- Emits pseudo-random candidate vectors on cand, samples the checker's combinational sat result, and streams only satisfying vectors out over a valid/ready port.
- Sits between a test controller, which supplies seed and sample count, and a downstream sample sink (scoreboard or FIFO).

Parameters:
- WIDTH, 512, total candidate width: concatenation of all checker inputs, var_0 in the LSBs.
- LANES, WIDTH/32, number of 32-bit LFSR lanes. WIDTH must equal 32*LANES (elaboration error otherwise).
- MAX_TRIES, 1048576, attempts per sample before timeout abort.
- CW, 21, attempt counter width (holds MAX_TRIES).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run when idle
- seed  in  32  run seed, captured on accepted start
- num_samples  in  16  samples requested; 0 completes immediately
- cand  out  WIDTH  registered candidate vector to the checker
- sat  in  1  checker result for the current cand (combinational, same cycle)
- sample_valid  out  1  sample_data holds a satisfying vector
- sample_ready  in  1  sink accepts sample
- sample_data  out  WIDTH  captured satisfying vector
- busy  out  1  high in SEARCH/HOLD
- done  out  1  one-cycle pulse at run end
- timeout  out  1  sticky; set on abort, cleared on next accepted start
- attempts  out  CW  attempts spent on the current sample

Behaviour:
- Reset (async, rst_n=0): state IDLE; all LFSR lanes 32'h1; cand=0, sample_data=0; sample_valid, busy, done, timeout = 0; attempts=0; remaining=0.
- Lane seeding on accepted start: lane[i] = seed ^ (i*32'h9E3779B9), computed mod 2^32. A lane that evaluates to 0 is replaced by 32'h1.
- cand = concatenation of lanes, lane 0 in the LSBs.
- LFSR step: 32-bit Galois, right shift. If the shifted-out bit is 1, XOR with mask 32'h80200003. All lanes step together.
- IDLE:
  - start=1 loads the seeds, remaining=num_samples, attempts=0, clears timeout, goes to SEARCH.
  - If num_samples=0: go straight back to IDLE with a done pulse next cycle. No cand update.
- SEARCH (one attempt per cycle):
  - sat=1: sample_data<=cand, sample_valid<=1, go to HOLD. The LFSR does not step.
  - sat=0: LFSR steps, attempts+1.
  - Abort: when attempts reaches MAX_TRIES-1 and sat=0, set timeout, pulse done, go to IDLE. No partial sample is emitted.
- HOLD:
  - sample_valid=1 and sample_data stable until sample_valid&&sample_ready.
  - On handshake: sample_valid<=0, remaining-1, attempts<=0, LFSR steps, so the same vector is never emitted twice in a row.
  - If remaining becomes 0: go to IDLE and pulse done. Otherwise return to SEARCH.
  - sat is ignored in HOLD.
- start is ignored while busy. An IDLE start coinciding with the done pulse cycle is accepted.
- sample_ready while sample_valid=0 has no effect.
- Latency: sat=1 in cycle N gives sample_valid=1 in cycle N+1. After a handshake in cycle M, the next attempt uses the new cand in cycle M+1.
- Deassertion of rst_n mid-run aborts immediately to reset values. No done pulse.
- All counters are unsigned. attempts never wraps because the abort fires first.

Decomposition:
- Shared package constraint_sampler_pkg:
  - state enum {IDLE, SEARCH, HOLD}
  - LFSR_MASK = 32'h80200003
  - SEED_STRIDE = 32'h9E3779B9
  - function lfsr_step(logic [31:0]) returning the next state
- Sub-module: lfsr32_lane, a single lane with load/step/seed-zero substitution, instantiated LANES times by generate.

Test Plan:
- Stub checker sat=(cand[7:0]==8'h00), seed=32'h1, num_samples=4, sample_ready=1 -> 4 handshakes, each sample_data[7:0]==0, no repeated vectors, done pulses once, timeout=0.
- Stub sat=1 constant, num_samples=3, sample_ready held 0 for 10 cycles -> sample_valid stays 1 with sample_data stable; after ready, the next 2 samples follow with 1 SEARCH cycle each.
- Stub sat=0 constant, MAX_TRIES overridden to 16, num_samples=1 -> after exactly 16 SEARCH cycles, done pulses, timeout=1, sample_valid never asserts; the next start clears timeout.
- num_samples=0 with start -> done pulses the following cycle, busy never asserts, cand unchanged.
- seed=32'h0 -> lane 0 starts at 32'h1, lane 1 at 32'h9E3779B9; the first cand after the step matches a lfsr_step reference model.
- Drop rst_n in HOLD with sample_valid=1 -> all outputs return to reset values asynchronously. After release, start is accepted normally.
